// File: rtl/parity_check_rx.sv
// parity_check_rx
//   Receive-side parity checker. A word and its transmitted parity bit are
//   taken in on a valid/ready stream. The parity is recomputed over a
//   two-stage pipeline, and the word is forwarded unmodified together with a
//   per-word error flag. A saturating error counter and a sticky error flag
//   give a status readout, and both are cleared synchronously by clr.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake
//   in_data[DATA_W], in_par received word and its parity bit
//   out_valid/out_ready     downstream handshake
//   out_data[DATA_W]        checked word, unmodified
//   out_err                 parity mismatch for out_data (qualified by out_valid)
//   err_cnt[CNT_W]          count of errored output transfers, saturating
//   err_sticky              set on the first errored output transfer
//   clr                     synchronous clear of err_cnt / err_sticky
module parity_check_rx #(
    parameter int DATA_W  = 16,
    parameter int PAR_ODD = 0,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky,
    input  logic              clr
);

    // One partial parity bit per 4-bit group; the top group is narrower when
    // DATA_W is not a multiple of 4.
    localparam int NGRP = (DATA_W + 3) / 4;
    localparam logic PAR_ODD_BIT = (PAR_ODD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NGRP-1:0]   grp_par;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_par;
    logic [NGRP-1:0]   s1_grp;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_err;

    logic              adv1;
    logic              adv2;
    logic              err_next;
    logic              err_xfer;

    always_comb begin
        grp_par = '0;
        for (int i = 0; i < DATA_W; i++) begin
            grp_par[i/4] = grp_par[i/4] ^ in_data[i];
        end
    end

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    // Odd parity inverts the sense of a good word, hence the final XOR.
    assign err_next = (^s1_grp) ^ s1_par ^ PAR_ODD_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_par   <= 1'b0;
            s1_grp   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_par  <= in_par;
                s1_grp  <= grp_par;
            end
        end
    end

    // When S1 is empty and S2 advances, S2 takes a bubble (s2_valid=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
                s2_err  <= err_next;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

    assign err_xfer = s2_valid & out_ready & s2_err;

    // clr wins over a same-cycle errored transfer; that error is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (err_xfer) begin
            err_sticky <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
